alu_sequencer: RTL and testbench
================================

# alu_sequencer

Controller that sequences one ALU-class instruction through the CPU `ALU` datapath: 8-bit arithmetic/logic on A, INC/DEC r, and the four accumulator/flag ops DAA/CPL/SCF/CCF. It sits between the instruction decoder and the `ALU`, register file and memory port, and sources the non-accumulator operand from a register, an immediate byte or (HL). It drives `ALU` function control, flag save and write strobes, and runs read/modify/write bus handshakes for (HL) operands.

## Interface
Parameters:
- none (fixed 8-bit datapath)

Ports:
- `i_Clk`  in  1  system clock
- `i_Reset_n`  in  1  asynchronous, active-low reset
- `i_Enable`  in  1  clock enable; when low, all state, outputs and latches hold
- `i_Start`  in  1  decoder pulse; sampled only in IDLE
- `i_Opcode`  in  8  instruction opcode, valid with `i_Start`
- `o_Busy`  out  1  high in every state except IDLE
- `o_Done`  out  1  one-cycle completion pulse
- `o_Illegal`  out  1  with `o_Done`: opcode not handled, no side effects
- `o_Opcode`  out  8  latched opcode, routed to `ALU` `i_Opcode`
- `o_Function_Control`  out  6  routed to `ALU` `i_Function_Control`
- `o_Save_Flags`  out  1  routed to `ALU` `i_Save_Flags`
- `o_Parameter`  out  8  operand routed to `ALU` `i_Parameter`
- `i_Result`  in  8  `ALU` `o_Result`
- `o_Reg_Sel`  out  3  register-file read index (B,C,D,E,H,L,-,A = 0..7)
- `i_Reg_Data`  in  8  register-file read data, combinational from `o_Reg_Sel`
- `o_Reg_Write`  out  1  register-file write strobe; data = `i_Result`, index = `o_Reg_Sel`
- `o_A_Write`  out  1  `ALU` A write strobe (`i_Write[0]`); data = `i_Result`
- `o_Mem_Req`  out  1  bus request, held until `i_Mem_Ack`
- `o_Mem_Wr`  out  1  request direction: 1 = write (address = HL) / 0 = read
- `o_Mem_Addr_Sel`  out  1  0 = HL, 1 = PC (immediate)
- `o_Mem_Wdata`  out  8  write data
- `i_Mem_Ack`  in  1  transfer complete this cycle
- `i_Mem_Rdata`  in  8  read data, valid with `i_Mem_Ack`

## Operation
Opcode classes, decided in IDLE:
- MAIN_R: 0x80–0xBF. Operand index = op[2:0]; index 6 = (HL).
- MAIN_I: 0xC6/CE/D6/DE/E6/EE/F6/FE. Operand is the immediate byte.
- INCDEC: 00rrr10d (0x04..0x3D). d=1 is DEC. Target index = op[5:3]; index 6 = (HL).
- MISC: 0x27/2F/37/3F.
- Anything else: ILLEGAL.

Function control:
- MAIN: 6'b000001
- INC: 6'b000010
- DEC: 6'b000110
- MISC: 6'b100000
- Bit 4 is always 0. All bits are 0 outside EXEC.

States:
- IDLE: on `i_Start & i_Enable`, latch the opcode.
  - Operand in (HL), or MAIN_I → RD.
  - ILLEGAL → IDLE with `o_Done`, `o_Illegal`.
  - Otherwise → EXEC.
- RD: `o_Mem_Req=1`, `o_Mem_Wr=0`. On `i_Mem_Ack`, latch `i_Mem_Rdata` into OPR and go to EXEC.
- EXEC: drive function control and `o_Save_Flags=1`. `o_Parameter` = OPR if it came from memory, else `i_Reg_Data`.
  - MAIN with op[5:3]≠7 (not CP): `o_A_Write=1`.
  - MAIN CP: no result write, flags only.
  - MISC: `o_A_Write=1` (CPL/DAA change A; SCF/CCF write A unchanged).
  - INCDEC register target: index 7 → `o_A_Write`, others → `o_Reg_Write`.
  - INCDEC (HL): capture `i_Result` into WDATA and go to WR.
  - All other cases: `o_Done`, return to IDLE.
- WR: `o_Mem_Req=1`, `o_Mem_Wr=1`, `o_Mem_Wdata`=WDATA, address HL. On `i_Mem_Ack`: `o_Done`, go to IDLE.

## Timing
- Reset: state IDLE; OPR, WDATA and the latched opcode are 0x00; every output is 0.
- Outputs are combinational from state and latches. No output is registered beyond the state.
- Register operand: `i_Start` at cycle 0, EXEC with `o_Done` at cycle 1. Flags and results commit at the cycle-1 clock edge.
- Memory read: EXEC is the cycle after ack; minimum 3 cycles from start to done.
- INC/DEC (HL): minimum 4 cycles.
- Ack in the same cycle as the request raises is legal. Unbounded ack wait is legal.
- `i_Start` while busy is ignored. Back-to-back starts: a new `i_Start` is accepted in the cycle after `o_Done`.
- `i_Enable` low in any state freezes everything. A request stays asserted and an ack is ignored (the bus must hold ack).
- Reset mid-op aborts immediately. No write strobe may follow the reset assertion.

## Structure
- Shared CPU package holds:
  - function-control localparams (FC_MAIN, FC_INC, FC_DEC, FC_MISC)
  - register index constants (REG_B..REG_A, REG_HL_MEM=6)
  - the state enum
- Optional sub-module `alu_op_decode`: combinational opcode → class, operand source and function-control vector.

## Test plan
- `ADD A,B` (0x80), reg B=0x05: cycle 1 shows FC=000001, `o_Parameter`=0x05, `o_A_Write`, `o_Save_Flags`, `o_Done`; 2 cycles total.
- `CP 0x3C` (0xFE) with ack delayed 3 cycles: request held for 4 cycles, `o_Parameter`=0x3C, `o_A_Write`=0, `o_Done` one cycle after ack.
- `DEC (HL)` (0x35), read 0x10, `i_Result`=0x0F: WR drives `o_Mem_Wdata`=0x0F, `o_Mem_Wr`=1, `o_Done` on the write ack.
- `INC A` (0x3C): FC=000010, `o_Reg_Sel`=7, `o_A_Write`=1, `o_Reg_Write`=0.
- Opcode 0x76: `o_Done` and `o_Illegal` at cycle 0, no strobes. `i_Start` pulsed during a busy RD is ignored.
- Reset asserted in RD, then `i_Enable` low for 2 cycles during WR: reset returns IDLE with zero outputs. The frozen WR holds `o_Mem_Req` and completes only after enable returns.

Source files
------------

// File: rtl/alu_sequencer_pkg.sv
// Shared definitions for the ALU instruction sequencer: function-control
// encodings, register-file indices and the controller state type.
package alu_sequencer_pkg;

    localparam logic [5:0] FC_NONE = 6'b000000;
    localparam logic [5:0] FC_MAIN = 6'b000001;
    localparam logic [5:0] FC_INC  = 6'b000010;
    localparam logic [5:0] FC_DEC  = 6'b000110;
    localparam logic [5:0] FC_MISC = 6'b100000;

    localparam logic [2:0] REG_B      = 3'd0;
    localparam logic [2:0] REG_C      = 3'd1;
    localparam logic [2:0] REG_D      = 3'd2;
    localparam logic [2:0] REG_E      = 3'd3;
    localparam logic [2:0] REG_H      = 3'd4;
    localparam logic [2:0] REG_L      = 3'd5;
    localparam logic [2:0] REG_HL_MEM = 3'd6;
    localparam logic [2:0] REG_A      = 3'd7;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EXEC = 2'd2,
        ST_WR   = 2'd3
    } state_e;

endpackage

// File: rtl/alu_op_decode.sv
// Combinational opcode classifier: legality, operand source, target index
// and ALU function-control vector for one ALU-class opcode.
module alu_op_decode
    import alu_sequencer_pkg::*;
(
    input  logic [7:0] opcode_i,
    output logic       legal_o,
    output logic       incdec_o,
    output logic       mem_op_o,
    output logic       imm_o,
    output logic       cp_o,
    output logic [2:0] idx_o,
    output logic [5:0] fc_o
);

    // Classify the opcode into MAIN_R, MAIN_I, INCDEC, MISC or illegal.
    always_comb begin
        legal_o  = 1'b0;
        incdec_o = 1'b0;
        mem_op_o = 1'b0;
        imm_o    = 1'b0;
        cp_o     = 1'b0;
        idx_o    = REG_A;
        fc_o     = FC_NONE;
        if (opcode_i[7:6] == 2'b10) begin
            legal_o  = 1'b1;
            idx_o    = opcode_i[2:0];
            mem_op_o = (opcode_i[2:0] == REG_HL_MEM);
            cp_o     = (opcode_i[5:3] == 3'd7);
            fc_o     = FC_MAIN;
        end else if ((opcode_i[7:6] == 2'b11) && (opcode_i[2:0] == 3'b110)) begin
            legal_o  = 1'b1;
            mem_op_o = 1'b1;
            imm_o    = 1'b1;
            cp_o     = (opcode_i[5:3] == 3'd7);
            fc_o     = FC_MAIN;
        end else if ((opcode_i[7:6] == 2'b00) && (opcode_i[2:1] == 2'b10)) begin
            legal_o  = 1'b1;
            incdec_o = 1'b1;
            idx_o    = opcode_i[5:3];
            mem_op_o = (opcode_i[5:3] == REG_HL_MEM);
            fc_o     = opcode_i[0] ? FC_DEC : FC_INC;
        end else if ((opcode_i[7:5] == 3'b001) && (opcode_i[2:0] == 3'b111)) begin
            legal_o  = 1'b1;
            fc_o     = FC_MISC;
        end else begin
            legal_o  = 1'b0;
        end
    end

endmodule

// File: rtl/alu_sequencer.sv
// Sequences one ALU-class instruction through the ALU, register file and
// memory port, including read/modify/write for (HL) operands.
module alu_sequencer
    import alu_sequencer_pkg::*;
(
    input  logic       i_Clk,
    input  logic       i_Reset_n,
    input  logic       i_Enable,
    input  logic       i_Start,
    input  logic [7:0] i_Opcode,
    output logic       o_Busy,
    output logic       o_Done,
    output logic       o_Illegal,
    output logic [7:0] o_Opcode,
    output logic [5:0] o_Function_Control,
    output logic       o_Save_Flags,
    output logic [7:0] o_Parameter,
    input  logic [7:0] i_Result,
    output logic [2:0] o_Reg_Sel,
    input  logic [7:0] i_Reg_Data,
    output logic       o_Reg_Write,
    output logic       o_A_Write,
    output logic       o_Mem_Req,
    output logic       o_Mem_Wr,
    output logic       o_Mem_Addr_Sel,
    output logic [7:0] o_Mem_Wdata,
    input  logic       i_Mem_Ack,
    input  logic [7:0] i_Mem_Rdata
);

    state_e     state_q, state_d;
    logic [7:0] opcode_q, opcode_d;
    logic [7:0] opr_q, opr_d;
    logic [7:0] wdata_q, wdata_d;

    logic [7:0] dec_op_s;
    logic       legal_s, incdec_s, mem_op_s, imm_s, cp_s;
    logic [2:0] idx_s;
    logic [5:0] fc_s;

    // In IDLE the incoming opcode is classified; afterwards the latched one.
    assign dec_op_s = (state_q == ST_IDLE) ? i_Opcode : opcode_q;
    assign o_Opcode = opcode_q;

    alu_op_decode u_decode (
        .opcode_i (dec_op_s),
        .legal_o  (legal_s),
        .incdec_o (incdec_s),
        .mem_op_o (mem_op_s),
        .imm_o    (imm_s),
        .cp_o     (cp_s),
        .idx_o    (idx_s),
        .fc_o     (fc_s)
    );

    // State and latches; the clock enable freezes everything.
    always_ff @(posedge i_Clk or negedge i_Reset_n) begin
        if (!i_Reset_n) begin
            state_q  <= ST_IDLE;
            opcode_q <= 8'h00;
            opr_q    <= 8'h00;
            wdata_q  <= 8'h00;
        end else if (i_Enable) begin
            state_q  <= state_d;
            opcode_q <= opcode_d;
            opr_q    <= opr_d;
            wdata_q  <= wdata_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d            = state_q;
        opcode_d           = opcode_q;
        opr_d              = opr_q;
        wdata_d            = wdata_q;
        o_Busy             = 1'b0;
        o_Done             = 1'b0;
        o_Illegal          = 1'b0;
        o_Function_Control = FC_NONE;
        o_Save_Flags       = 1'b0;
        o_Parameter        = 8'h00;
        o_Reg_Sel          = 3'd0;
        o_Reg_Write        = 1'b0;
        o_A_Write          = 1'b0;
        o_Mem_Req          = 1'b0;
        o_Mem_Wr           = 1'b0;
        o_Mem_Addr_Sel     = 1'b0;
        o_Mem_Wdata        = 8'h00;
        case (state_q)
            ST_IDLE: begin
                if (i_Start && i_Enable) begin
                    opcode_d = i_Opcode;
                    if (!legal_s) begin
                        o_Done    = 1'b1;
                        o_Illegal = 1'b1;
                        state_d   = ST_IDLE;
                    end else if (mem_op_s) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_EXEC;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD: begin
                o_Busy         = 1'b1;
                o_Mem_Req      = 1'b1;
                o_Mem_Addr_Sel = imm_s;
                if (i_Mem_Ack) begin
                    opr_d   = i_Mem_Rdata;
                    state_d = ST_EXEC;
                end else begin
                    state_d = ST_RD;
                end
            end
            ST_EXEC: begin
                o_Busy             = 1'b1;
                o_Function_Control = fc_s;
                o_Save_Flags       = 1'b1;
                o_Reg_Sel          = idx_s;
                o_Parameter        = mem_op_s ? opr_q : i_Reg_Data;
                if (incdec_s && mem_op_s) begin
                    wdata_d = i_Result;
                    state_d = ST_WR;
                end else begin
                    o_Done  = 1'b1;
                    state_d = ST_IDLE;
                    if (incdec_s) begin
                        o_A_Write   = (idx_s == REG_A);
                        o_Reg_Write = (idx_s != REG_A);
                    end else begin
                        // CP only updates flags; MISC always rewrites A.
                        o_A_Write = ~cp_s;
                    end
                end
            end
            ST_WR: begin
                o_Busy      = 1'b1;
                o_Mem_Req   = 1'b1;
                o_Mem_Wr    = 1'b1;
                o_Mem_Wdata = wdata_q;
                if (i_Mem_Ack && i_Enable) begin
                    o_Done  = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_WR;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Self-checking bench for alu_sequencer: scripted scenarios with a
// scoreboard of expected completion signatures popped on every o_Done.
module tb_alu_sequencer;

    localparam logic [5:0] X_MAIN = 6'b000001;
    localparam logic [5:0] X_INC  = 6'b000010;
    localparam logic [5:0] X_DEC  = 6'b000110;
    localparam logic [5:0] X_MISC = 6'b100000;

    logic       i_Clk = 1'b0;
    logic       i_Reset_n, i_Enable, i_Start, i_Mem_Ack;
    logic [7:0] i_Opcode, i_Result, i_Reg_Data, i_Mem_Rdata;
    logic       o_Busy, o_Done, o_Illegal, o_Save_Flags, o_Reg_Write, o_A_Write;
    logic       o_Mem_Req, o_Mem_Wr, o_Mem_Addr_Sel;
    logic [7:0] o_Opcode, o_Parameter, o_Mem_Wdata;
    logic [5:0] o_Function_Control;
    logic [2:0] o_Reg_Sel;

    logic [7:0] regs [8];
    logic [9:0] sb [$];
    logic [9:0] exp_v;
    logic [9:0] done_view;
    int         vecs = 0;
    int         errs = 0;

    always #5 i_Clk = ~i_Clk;

    assign i_Reg_Data = regs[o_Reg_Sel];
    // Completion signature: {illegal, A write, reg write, mem write, function control}
    assign done_view  = {o_Illegal, o_A_Write, o_Reg_Write, o_Mem_Wr, o_Function_Control};

    alu_sequencer dut (
        .i_Clk (i_Clk), .i_Reset_n (i_Reset_n), .i_Enable (i_Enable),
        .i_Start (i_Start), .i_Opcode (i_Opcode),
        .o_Busy (o_Busy), .o_Done (o_Done), .o_Illegal (o_Illegal),
        .o_Opcode (o_Opcode), .o_Function_Control (o_Function_Control),
        .o_Save_Flags (o_Save_Flags), .o_Parameter (o_Parameter),
        .i_Result (i_Result), .o_Reg_Sel (o_Reg_Sel), .i_Reg_Data (i_Reg_Data),
        .o_Reg_Write (o_Reg_Write), .o_A_Write (o_A_Write),
        .o_Mem_Req (o_Mem_Req), .o_Mem_Wr (o_Mem_Wr), .o_Mem_Addr_Sel (o_Mem_Addr_Sel),
        .o_Mem_Wdata (o_Mem_Wdata), .i_Mem_Ack (i_Mem_Ack), .i_Mem_Rdata (i_Mem_Rdata)
    );

    task automatic next_cycle();
        @(posedge i_Clk);
        #1;
    endtask

    task automatic drive_start(input logic [7:0] op, input logic push, input logic [9:0] exp);
        i_Opcode = op;
        i_Start  = 1'b1;
        if (push) sb.push_back(exp);
    endtask

    task automatic test_reset();
        i_Reset_n = 1'b0; i_Enable = 1'b1; i_Start = 1'b0; i_Opcode = 8'h00;
        i_Result = 8'h00; i_Mem_Ack = 1'b0; i_Mem_Rdata = 8'h00;
        for (int r = 0; r < 8; r++) regs[r] = 8'(8'h30 + r);
        repeat (2) @(posedge i_Clk);
        @(negedge i_Clk);
        vecs++; if ({o_Busy, o_Done, o_Illegal, o_Save_Flags, o_Reg_Write, o_A_Write, o_Mem_Req, o_Mem_Wr, o_Mem_Addr_Sel} !== 9'd0)
            begin errs++; $display("FAIL reset_strobes: got %b want 0", {o_Busy, o_Done, o_Illegal, o_Save_Flags, o_Reg_Write, o_A_Write, o_Mem_Req, o_Mem_Wr, o_Mem_Addr_Sel}); end
        vecs++; if ({o_Opcode, o_Function_Control, o_Parameter, o_Reg_Sel, o_Mem_Wdata} !== 33'd0)
            begin errs++; $display("FAIL reset_buses: got %h want 0", {o_Opcode, o_Function_Control, o_Parameter, o_Reg_Sel, o_Mem_Wdata}); end
        next_cycle();
        i_Reset_n = 1'b1;
    endtask

    task automatic test_add_reg();
        regs[0] = 8'h05;
        drive_start(8'h80, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, X_MAIN});
        @(negedge i_Clk);
        vecs++; if ({o_Busy, o_Done} !== 2'b00) begin errs++; $display("FAIL add_c0: busy/done got %b want 00", {o_Busy, o_Done}); end
        next_cycle();
        i_Start = 1'b0;
        @(negedge i_Clk);
        vecs++; if (o_Parameter !== 8'h05) begin errs++; $display("FAIL add_param: got %h want 05", o_Parameter); end
        vecs++; if ({o_Save_Flags, o_Done, o_Busy} !== 3'b111) begin errs++; $display("FAIL add_exec: save/done/busy got %b want 111", {o_Save_Flags, o_Done, o_Busy}); end
        if (o_Done) begin
            vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            if (done_view !== exp_v) begin errs++; $display("FAIL add_done: got %b want %b", done_view, exp_v); end
        end
        next_cycle();
        @(negedge i_Clk);
        vecs++; if (o_Busy !== 1'b0) begin errs++; $display("FAIL add_idle: busy got %b want 0", o_Busy); end
        next_cycle();
    endtask

    task automatic test_cp_imm_delayed();
        int req_cycles = 0;
        drive_start(8'hFE, 1'b1, {1'b0, 1'b0, 1'b0, 1'b0, X_MAIN});
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            i_Start     = (c == 2);
            i_Opcode    = (c == 2) ? 8'h76 : 8'h00;
            i_Mem_Ack   = (c == 4);
            i_Mem_Rdata = (c == 4) ? 8'h3C : 8'hEE;
            @(negedge i_Clk);
            if (o_Mem_Req) req_cycles++;
            if (c == 1) begin
                vecs++; if ({o_Mem_Addr_Sel, o_Mem_Wr} !== 2'b10) begin errs++; $display("FAIL cp_rd_dir: addr_sel/wr got %b want 10", {o_Mem_Addr_Sel, o_Mem_Wr}); end
            end
            if (c == 2) begin
                vecs++; if ({o_Done, o_Illegal, o_Opcode} !== {2'b00, 8'hFE}) begin errs++; $display("FAIL cp_busy_start: got %h want 0fe", {o_Done, o_Illegal, o_Opcode}); end
            end
            next_cycle();
        end
        i_Start = 1'b0; i_Mem_Ack = 1'b0;
        vecs++; if (req_cycles != 4) begin errs++; $display("FAIL cp_req_len: got %0d want 4", req_cycles); end
        @(negedge i_Clk);
        vecs++; if (o_Parameter !== 8'h3C) begin errs++; $display("FAIL cp_param: got %h want 3c", o_Parameter); end
        vecs++; if (o_Done !== 1'b1) begin errs++; $display("FAIL cp_done: got %b want 1", o_Done); end
        if (o_Done) begin
            vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            if (done_view !== exp_v) begin errs++; $display("FAIL cp_view: got %b want %b", done_view, exp_v); end
        end
        next_cycle();
    endtask

    task automatic test_dec_hl();
        drive_start(8'h35, 1'b1, {1'b0, 1'b0, 1'b0, 1'b1, 6'b000000});
        next_cycle();
        i_Start = 1'b0; i_Mem_Ack = 1'b1; i_Mem_Rdata = 8'h10;
        @(negedge i_Clk);
        vecs++; if ({o_Mem_Req, o_Mem_Wr, o_Mem_Addr_Sel} !== 3'b100) begin errs++; $display("FAIL dec_rd: req/wr/sel got %b want 100", {o_Mem_Req, o_Mem_Wr, o_Mem_Addr_Sel}); end
        next_cycle();
        i_Mem_Ack = 1'b0; i_Result = 8'h0F;
        @(negedge i_Clk);
        vecs++; if ({o_Function_Control, o_Parameter} !== {X_DEC, 8'h10}) begin errs++; $display("FAIL dec_exec: fc/param got %h want %h", {o_Function_Control, o_Parameter}, {X_DEC, 8'h10}); end
        vecs++; if ({o_Save_Flags, o_Done, o_A_Write, o_Reg_Write, o_Mem_Req} !== 5'b10000) begin errs++; $display("FAIL dec_exec_strobes: got %b want 10000", {o_Save_Flags, o_Done, o_A_Write, o_Reg_Write, o_Mem_Req}); end
        next_cycle();
        i_Result = 8'hAA;
        @(negedge i_Clk);
        vecs++; if ({o_Mem_Req, o_Mem_Wr, o_Done, o_Mem_Wdata} !== {3'b110, 8'h0F}) begin errs++; $display("FAIL dec_wr_wait: got %h want 60f", {o_Mem_Req, o_Mem_Wr, o_Done, o_Mem_Wdata}); end
        next_cycle();
        i_Mem_Ack = 1'b1;
        @(negedge i_Clk);
        vecs++; if (o_Done !== 1'b1) begin errs++; $display("FAIL dec_wr_done: got %b want 1", o_Done); end
        if (o_Done) begin
            vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            if (done_view !== exp_v) begin errs++; $display("FAIL dec_view: got %b want %b", done_view, exp_v); end
        end
        next_cycle();
        i_Mem_Ack = 1'b0;
    endtask

    task automatic test_incdec_reg();
        logic [7:0] op, pv;
        logic [2:0] sel;
        logic [5:0] fc;
        logic       to_a;
        regs[7] = 8'h41; regs[1] = 8'h80;
        for (int k = 0; k < 2; k++) begin
            op   = (k == 0) ? 8'h3C : 8'h0D;
            sel  = (k == 0) ? 3'd7  : 3'd1;
            pv   = (k == 0) ? 8'h41 : 8'h80;
            fc   = (k == 0) ? X_INC : X_DEC;
            to_a = (k == 0);
            drive_start(op, 1'b1, {1'b0, to_a, ~to_a, 1'b0, fc});
            next_cycle();
            i_Start = 1'b0;
            @(negedge i_Clk);
            vecs++; if ({o_Reg_Sel, o_Parameter} !== {sel, pv}) begin errs++; $display("FAIL incdec_sel_param[%0d]: got %h want %h", k, {o_Reg_Sel, o_Parameter}, {sel, pv}); end
            vecs++; if (o_Done !== 1'b1) begin errs++; $display("FAIL incdec_done[%0d]: got %b want 1", k, o_Done); end
            if (o_Done) begin
                vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
                if (done_view !== exp_v) begin errs++; $display("FAIL incdec_view[%0d]: got %b want %b", k, done_view, exp_v); end
            end
            next_cycle();
        end
    endtask

    task automatic test_back_to_back();
        drive_start(8'h76, 1'b1, {1'b1, 1'b0, 1'b0, 1'b0, 6'b000000});
        @(negedge i_Clk);
        vecs++; if ({o_Done, o_Illegal, o_Busy, o_Save_Flags, o_Mem_Req} !== 5'b11000) begin errs++; $display("FAIL illegal_c0: got %b want 11000", {o_Done, o_Illegal, o_Busy, o_Save_Flags, o_Mem_Req}); end
        if (o_Done) begin
            vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            if (done_view !== exp_v) begin errs++; $display("FAIL illegal_view: got %b want %b", done_view, exp_v); end
        end
        next_cycle();
        drive_start(8'h2F, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, X_MISC});
        next_cycle();
        drive_start(8'h80, 1'b0, 10'd0);
        @(negedge i_Clk);
        vecs++; if ({o_Done, o_Opcode} !== {1'b1, 8'h2F}) begin errs++; $display("FAIL misc_done: got %h want 12f", {o_Done, o_Opcode}); end
        if (o_Done) begin
            vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            if (done_view !== exp_v) begin errs++; $display("FAIL misc_view: got %b want %b", done_view, exp_v); end
        end
        next_cycle();
        i_Start = 1'b0;
        @(negedge i_Clk);
        vecs++; if (o_Busy !== 1'b0) begin errs++; $display("FAIL b2b_ignored_start: busy got %b want 0", o_Busy); end
        next_cycle();
        regs[0] = 8'h5A;
        drive_start(8'hA8, 1'b1, {1'b0, 1'b1, 1'b0, 1'b0, X_MAIN});
        next_cycle();
        i_Start = 1'b0;
        @(negedge i_Clk);
        vecs++; if ({o_Done, o_Opcode, o_Parameter} !== {1'b1, 8'hA8, 8'h5A}) begin errs++; $display("FAIL xor_done: got %h want 1a85a", {o_Done, o_Opcode, o_Parameter}); end
        if (o_Done) begin
            vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            if (done_view !== exp_v) begin errs++; $display("FAIL xor_view: got %b want %b", done_view, exp_v); end
        end
        next_cycle();
    endtask

    task automatic test_reset_freeze();
        drive_start(8'h35, 1'b0, 10'd0);
        next_cycle();
        i_Start = 1'b0;
        #2 i_Reset_n = 1'b0;
        #1;
        vecs++; if ({o_Busy, o_Mem_Req, o_Mem_Wr, o_Done, o_Reg_Write, o_A_Write, o_Opcode} !== 14'd0) begin errs++; $display("FAIL reset_abort: got %h want 0", {o_Busy, o_Mem_Req, o_Mem_Wr, o_Done, o_Reg_Write, o_A_Write, o_Opcode}); end
        next_cycle();
        i_Reset_n = 1'b1;
        drive_start(8'h35, 1'b1, {1'b0, 1'b0, 1'b0, 1'b1, 6'b000000});
        next_cycle();
        i_Start = 1'b0; i_Mem_Ack = 1'b1; i_Mem_Rdata = 8'h7F;
        next_cycle();
        i_Mem_Ack = 1'b0; i_Result = 8'h80;
        next_cycle();
        i_Enable = 1'b0; i_Mem_Ack = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge i_Clk);
            vecs++; if ({o_Mem_Req, o_Mem_Wr, o_Done, o_Mem_Wdata} !== {3'b110, 8'h80}) begin errs++; $display("FAIL freeze_wr[%0d]: got %h want 680", c, {o_Mem_Req, o_Mem_Wr, o_Done, o_Mem_Wdata}); end
            next_cycle();
        end
        i_Enable = 1'b1;
        @(negedge i_Clk);
        vecs++; if (o_Done !== 1'b1) begin errs++; $display("FAIL freeze_done: got %b want 1", o_Done); end
        if (o_Done) begin
            vecs++; exp_v = (sb.size() > 0) ? sb.pop_front() : 10'h3FF;
            if (done_view !== exp_v) begin errs++; $display("FAIL freeze_view: got %b want %b", done_view, exp_v); end
        end
        next_cycle();
        i_Mem_Ack = 1'b0;
        @(negedge i_Clk);
        vecs++; if (o_Busy !== 1'b0) begin errs++; $display("FAIL freeze_idle: busy got %b want 0", o_Busy); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_add_reg();
        test_cp_imm_delayed();
        test_dec_hl();
        test_incdec_reg();
        test_back_to_back();
        test_reset_freeze();
        vecs++; if (sb.size() != 0) begin errs++; $display("FAIL scoreboard_drain: got %0d left want 0", sb.size()); end
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
